// File: rtl/dcm_clkgen_prog_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcm_clkgen_prog_if
//  Purpose  : Bundles the request handshake, the DCM_CLKGEN programming pins
//             and the status outputs of dcm_clkgen_prog into one interface.
//  Ports    : none (pure signal bundle; clk / rst_n stay plain module ports)
//    cfg_mult[7:0], cfg_div[7:0], cfg_valid   requester -> controller
//    cfg_ready                                 controller -> requester
//    prog_en, prog_data                        controller -> DCM PROGEN/PROGDATA
//    prog_done, dcm_locked                     DCM -> controller (asynchronous)
//    busy, status_done, status_error,
//    error_code[1:0], cur_mult[7:0],
//    cur_div[7:0]                              controller -> requester
//  Modports : master = requester plus DCM side, slave = the controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface dcm_clkgen_prog_if;
  logic [7:0] cfg_mult;
  logic [7:0] cfg_div;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       prog_en;
  logic       prog_data;
  logic       prog_done;
  logic       dcm_locked;
  logic       busy;
  logic       status_done;
  logic       status_error;
  logic [1:0] error_code;
  logic [7:0] cur_mult;
  logic [7:0] cur_div;

  // The master side drives the request and also models the DCM pins.
  modport master (
    output cfg_mult, cfg_div, cfg_valid, prog_done, dcm_locked,
    input  cfg_ready, prog_en, prog_data, busy, status_done, status_error,
           error_code, cur_mult, cur_div
  );

  modport slave (
    input  cfg_mult, cfg_div, cfg_valid, prog_done, dcm_locked,
    output cfg_ready, prog_en, prog_data, busy, status_done, status_error,
           error_code, cur_mult, cur_div
  );
endinterface
`default_nettype wire

// File: rtl/dcm_clkgen_prog.sv
`default_nettype none
// ============================================================================
//  Module   : dcm_clkgen_prog
//  Purpose  : Serial programming controller for the DCM_CLKGEN dynamic
//             reconfiguration port. A requested M/D pair is accepted through a
//             valid/ready handshake, shifted out as LoadD, LoadM and GO
//             frames on PROGEN/PROGDATA, then PROGDONE and LOCKED are awaited
//             and the outcome is reported as a done or error pulse.
//  Ports    :
//    clk    in   PROGCLK-domain clock (same net feeds DCM PROGCLK)
//    rst_n  in   synchronous active-low reset
//    bus    slave modport of dcm_clkgen_prog_if:
//      cfg_mult/cfg_div in  M-1 / D-1 request, cfg_valid in, cfg_ready out
//      prog_en/prog_data out to DCM, prog_done/dcm_locked in from DCM
//      busy, status_done, status_error, error_code, cur_mult, cur_div out
//  Parameters:
//    GAP_CYCLES   PROGEN-low cycles between frames (>= 1)
//    DONE_TIMEOUT cycles allowed from GO to PROGDONE handshake (>= 2)
//    LOCK_TIMEOUT cycles allowed from PROGDONE high to LOCKED (>= 2)
//  Revision : 1.0 - initial release
// ============================================================================
module dcm_clkgen_prog #(
  parameter int GAP_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 4096,
  parameter int LOCK_TIMEOUT = 65535
) (
  input wire logic         clk,
  input wire logic         rst_n,
  dcm_clkgen_prog_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_D    = 3'd1,
    S_GAP1      = 3'd2,
    S_LOAD_M    = 3'd3,
    S_GAP2      = 3'd4,
    S_GO        = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_WAIT_LOCK = 3'd7
  } state_t;

  // One shared counter serves frame bits, gaps and both timeouts. It is
  // sized for the largest of those, and never narrower than 5 bits so the
  // 4-bit frame-bit index below is always available.
  localparam int c_MAX_A   = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
  localparam int c_MAX_B   = (c_MAX_A > GAP_CYCLES) ? c_MAX_A : GAP_CYCLES;
  localparam int c_CNT_MAX = (c_MAX_B > 16) ? c_MAX_B : 16;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CW-1:0] c_CNT_SAT  = '1;
  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
  localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(9);
  localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'(GAP_CYCLES - 1);
  // The counter reads 0 in the first wait cycle and the error flag is
  // registered, so deciding at TIMEOUT-2 puts the error pulse exactly
  // TIMEOUT cycles after the last cycle of the preceding state.
  localparam logic [c_CW-1:0] c_DONE_LIM = c_CW'(DONE_TIMEOUT - 2);
  localparam logic [c_CW-1:0] c_LOCK_LIM = c_CW'(LOCK_TIMEOUT - 2);

  localparam logic [1:0] c_ERR_NONE = 2'd0;
  localparam logic [1:0] c_ERR_MULT = 2'd1;
  localparam logic [1:0] c_ERR_DONE = 2'd2;
  localparam logic [1:0] c_ERR_LOCK = 2'd3;

  localparam logic [7:0] c_RST_MULT = 8'd24;  // power-up M = 25
  localparam logic [7:0] c_RST_DIV  = 8'd0;   // power-up D = 1

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_seen_low;
  logic [7:0]      r_mult;
  logic [7:0]      r_div;
  logic            r_done_meta;
  logic            r_done_sync;
  logic            r_lock_meta;
  logic            r_lock_sync;
  logic            r_prog_en;
  logic            r_prog_data;
  logic            r_ready;
  logic            r_busy;
  logic            r_status_done;
  logic            r_status_error;
  logic [1:0]      r_error_code;
  logic [7:0]      r_cur_mult;
  logic [7:0]      r_cur_div;

  // --------------------------------------------------------------------------
  // Combinational next-state / next-output signals
  // --------------------------------------------------------------------------
  state_t          w_nxt_state;
  logic            w_cnt_clr;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            w_accept;
  logic            w_fire_done;
  logic            w_fire_err;
  logic [1:0]      w_err_code_nxt;
  logic            w_seen_low_nxt;
  logic [15:0]     w_frame_d;
  logic [15:0]     w_frame_m;
  logic            w_en_nxt;
  logic            w_data_nxt;

  always_comb begin
    w_nxt_state    = r_state;
    w_cnt_clr      = 1'b0;
    w_accept       = 1'b0;
    w_fire_done    = 1'b0;
    w_fire_err     = 1'b0;
    w_err_code_nxt = r_error_code;
    w_seen_low_nxt = r_seen_low;

    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (bus.cfg_valid && r_ready) begin
          w_accept = 1'b1;
          if (bus.cfg_mult == 8'd0) begin
            // M = 1 is not a legal DCM_CLKGEN multiplier; reject without
            // touching PROGEN.
            w_fire_err     = 1'b1;
            w_err_code_nxt = c_ERR_MULT;
          end else begin
            w_nxt_state    = S_LOAD_D;
            w_err_code_nxt = c_ERR_NONE;
          end
        end
      end

      S_LOAD_D: begin
        if (r_cnt == c_BIT_LAST) begin
          w_nxt_state = S_GAP1;
          w_cnt_clr   = 1'b1;
        end
      end

      S_GAP1: begin
        if (r_cnt >= c_GAP_LAST) begin
          w_nxt_state = S_LOAD_M;
          w_cnt_clr   = 1'b1;
        end
      end

      S_LOAD_M: begin
        if (r_cnt == c_BIT_LAST) begin
          w_nxt_state = S_GAP2;
          w_cnt_clr   = 1'b1;
        end
      end

      S_GAP2: begin
        if (r_cnt >= c_GAP_LAST) begin
          w_nxt_state = S_GO;
          w_cnt_clr   = 1'b1;
        end
      end

      S_GO: begin
        w_nxt_state    = S_WAIT_DONE;
        w_cnt_clr      = 1'b1;
        w_seen_low_nxt = 1'b0;
      end

      S_WAIT_DONE: begin
        // PROGDONE is still high from the previous command when GO is sent,
        // so only a low-then-high sequence marks completion of this one.
        if (!r_done_sync) begin
          w_seen_low_nxt = 1'b1;
        end
        if (r_seen_low && r_done_sync) begin
          w_nxt_state = S_WAIT_LOCK;
          w_cnt_clr   = 1'b1;
        end else if (r_cnt >= c_DONE_LIM) begin
          w_nxt_state    = S_IDLE;
          w_fire_err     = 1'b1;
          w_err_code_nxt = c_ERR_DONE;
        end
      end

      S_WAIT_LOCK: begin
        if (r_lock_sync) begin
          w_nxt_state = S_IDLE;
          w_fire_done = 1'b1;
        end else if (r_cnt >= c_LOCK_LIM) begin
          w_nxt_state    = S_IDLE;
          w_fire_err     = 1'b1;
          w_err_code_nxt = c_ERR_LOCK;
        end
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase

    // Saturating counter, cleared on every state change.
    if (w_cnt_clr) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == c_CNT_SAT) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + c_ONE;
    end

    // Frame bit k is shifted out while the counter holds k: two opcode bits
    // (1,0 = LoadD; 1,1 = LoadM) followed by the value LSB first. Bits 0/1
    // are constants, so the value latched at the accept edge is never needed
    // before it has been registered.
    w_frame_d = {6'd0, r_div,  1'b0, 1'b1};
    w_frame_m = {6'd0, r_mult, 1'b1, 1'b1};

    // Outputs are registered from the next state so that prog_en/prog_data
    // line up cycle for cycle with the state register.
    w_en_nxt   = (w_nxt_state == S_LOAD_D) || (w_nxt_state == S_LOAD_M) ||
                 (w_nxt_state == S_GO);
    w_data_nxt = 1'b0;
    if (w_nxt_state == S_LOAD_D) begin
      w_data_nxt = w_frame_d[w_cnt_nxt[3:0]];
    end else if (w_nxt_state == S_LOAD_M) begin
      w_data_nxt = w_frame_m[w_cnt_nxt[3:0]];
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_seen_low     <= 1'b0;
      r_mult         <= c_RST_MULT;
      r_div          <= c_RST_DIV;
      r_done_meta    <= 1'b0;
      r_done_sync    <= 1'b0;
      r_lock_meta    <= 1'b0;
      r_lock_sync    <= 1'b0;
      r_prog_en      <= 1'b0;
      r_prog_data    <= 1'b0;
      r_ready        <= 1'b0;
      r_busy         <= 1'b0;
      r_status_done  <= 1'b0;
      r_status_error <= 1'b0;
      r_error_code   <= c_ERR_NONE;
      r_cur_mult     <= c_RST_MULT;
      r_cur_div      <= c_RST_DIV;
    end else begin
      r_state        <= w_nxt_state;
      r_cnt          <= w_cnt_nxt;
      r_seen_low     <= w_seen_low_nxt;

      // Two-flop synchronisers for the DCM status pins.
      r_done_meta    <= bus.prog_done;
      r_done_sync    <= r_done_meta;
      r_lock_meta    <= bus.dcm_locked;
      r_lock_sync    <= r_lock_meta;

      if (w_accept) begin
        r_mult <= bus.cfg_mult;
        r_div  <= bus.cfg_div;
      end

      r_prog_en      <= w_en_nxt;
      r_prog_data    <= w_data_nxt;
      r_busy         <= (w_nxt_state != S_IDLE);
      // Ready is held low during the status pulse, so a new request lands no
      // earlier than the cycle after done/error.
      r_ready        <= (w_nxt_state == S_IDLE) && !w_fire_done && !w_fire_err;
      r_status_done  <= w_fire_done;
      r_status_error <= w_fire_err;
      r_error_code   <= w_err_code_nxt;

      if (w_fire_done) begin
        r_cur_mult <= r_mult;
        r_cur_div  <= r_div;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.cfg_ready    = r_ready;
  assign bus.prog_en      = r_prog_en;
  assign bus.prog_data    = r_prog_data;
  assign bus.busy         = r_busy;
  assign bus.status_done  = r_status_done;
  assign bus.status_error = r_status_error;
  assign bus.error_code   = r_error_code;
  assign bus.cur_mult     = r_cur_mult;
  assign bus.cur_div      = r_cur_div;

endmodule
`default_nettype wire
